// File: rtl/trivium_par.sv
// ---------------------------------------------------------------------------
// trivium_par
//   Trivium keystream generator producing W keystream bits per clock.
//   The 288-bit state is loaded from key/IV, warmed up for INIT_ROUNDS
//   single steps (W per cycle, no output), then streams keystream words
//   through a valid/ready handshake for as long as the consumer wants them.
//
// Parameters
//   W            keystream bits per cycle (1, 2, 4, 8, 16, 32 or 64)
//   INIT_ROUNDS  warm-up steps; must be a non-zero multiple of W
//
// Ports
//   clk       in   single rising-edge clock
//   rst       in   asynchronous active-high reset
//   key       in   80-bit key, sampled when load is high
//   iv        in   80-bit IV, sampled when load is high
//   load      in   single-cycle (re)key request, honoured in every state
//   ks_ready  in   consumer accepts the current word on this edge
//   pt_data   in   W-bit plaintext (only with TRIVIUM_PAR_XOR_EN)
//   ks_valid  out  ks_data carries a valid word
//   ks_data   out  keystream word (bit 0 earliest in time), or
//                  keystream ^ pt_data with TRIVIUM_PAR_XOR_EN;
//                  all-zero whenever ks_valid is low
//   busy      out  warm-up in progress
//
// Configuration macro
//   TRIVIUM_PAR_XOR_EN  adds pt_data and XORs it into ks_data
//
// State bit s_i of the Trivium description is held in s_q[i-1].
// ---------------------------------------------------------------------------
module trivium_par #(
  parameter int W           = 8,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [79:0]  key,
  input  logic [79:0]  iv,
  input  logic         load,
  input  logic         ks_ready,
`ifdef TRIVIUM_PAR_XOR_EN
  input  logic [W-1:0] pt_data,
`endif
  output logic         ks_valid,
  output logic [W-1:0] ks_data,
  output logic         busy
);

  localparam int INIT_CYCLES = INIT_ROUNDS / W;
  localparam int CNT_W       = $clog2(INIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(INIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN
  } state_t;

  state_t           fsm_q;
  state_t           fsm_d;
  logic [287:0]     s_q;
  logic [287:0]     s_load;
  logic [287:0]     s_walk;
  logic [287:0]     s_adv;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     ks_word;
  logic             advance;

  // Keystream bit of a state: z = t1 ^ t2 ^ t3 before the AND/feedback terms.
  function automatic logic trivium_z(input logic [287:0] s);
    return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
  endfunction

  // One Trivium step: three nonlinear feedbacks, each register shifts by one.
  function automatic logic [287:0] trivium_step(input logic [287:0] s);
    logic t1;
    logic t2;
    logic t3;
    t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
    t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
    t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
    return {s[286:177], t2, s[175:93], t1, s[91:0], t3};
  endfunction

  // Key in s1..s80, IV in s94..s173, s286..s288 set, everything else clear.
  assign s_load = {3'b111, 112'b0, iv, 13'b0, key};

  // Unrolled chain of W single steps. Word bit j is z of the state after
  // j steps, so bit 0 is the earliest keystream bit; the end of the chain
  // is the state that follows once the whole word has been used.
  always_comb begin
    s_walk  = s_q;
    ks_word = '0;
    for (int j = 0; j < W; j++) begin
      ks_word[j] = trivium_z(s_walk);
      s_walk     = trivium_step(s_walk);
    end
    s_adv = s_walk;
  end

  // Warm-up steps every cycle; in RUN the state only moves on a handshake,
  // which keeps the presented word stable while the consumer stalls.
  assign advance  = (fsm_q == INIT) || ((fsm_q == RUN) && ks_ready);
  assign ks_valid = (fsm_q == RUN);
  assign busy     = (fsm_q == INIT);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  // Next-state logic. A load request overrides everything, including a
  // handshake landing on the same edge: that word is still taken by the
  // consumer, and warm-up for the new key starts from the next cycle.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    fsm_d = IDLE;
      INIT:    if (cnt_q == CNT_LAST) fsm_d = RUN;
      RUN:     fsm_d = RUN;
      default: fsm_d = IDLE;
    endcase
    if (load) begin
      fsm_d = INIT;
    end
  end

  // Cipher state and warm-up counter. The counter saturates at its last
  // value so it cannot wrap while in INIT; RUN has no length limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q   <= '0;
      cnt_q <= '0;
    end else if (load) begin
      s_q   <= s_load;
      cnt_q <= '0;
    end else begin
      if (advance) begin
        s_q <= s_adv;
      end
      if ((fsm_q == INIT) && (cnt_q != CNT_LAST)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef TRIVIUM_PAR_XOR_EN
  // Plaintext path is combinational so data can be applied in the same
  // cycle it is presented; the zeroing rule still applies when not valid.
  assign ks_data = ks_valid ? (ks_word ^ pt_data) : '0;
`else
  assign ks_data = ks_valid ? ks_word : '0;
`endif

endmodule

// File: tb/tb_trivium_par.sv
// ---------------------------------------------------------------------------
// tb_trivium_par
//   Directed self-checking bench for trivium_par. A bit-serial Trivium
//   model written in the textbook 1-indexed form supplies the expected
//   keystream; timing expectations (144 warm-up cycles at W=8) are fixed
//   constants. Three instances: W=8 (main), W=1 and W=32.
//   Define TRIVIUM_PAR_XOR_EN to also exercise the plaintext XOR path.
// ---------------------------------------------------------------------------
module tb_trivium_par;

  localparam logic [79:0] KEY2 = 80'h3A9C_51E0_7B24_D8F6_0C13;
  localparam logic [79:0] IV2  = 80'hB5D2_0E47_96A1_3CF8_6B09;
  localparam logic [79:0] KEY3 = 80'hFFFF_0000_AAAA_5555_1234;
  localparam logic [79:0] IV3  = 80'h0000_0000_0000_0000_0000;
  localparam logic [79:0] KEY4 = 80'h0123_4567_89AB_CDEF_FEDC;
  localparam logic [79:0] IV4  = 80'h8000_0000_0000_0000_0001;

  logic        clk;
  logic        rst;
  logic [79:0] key;
  logic [79:0] iv;
  logic        load;
  logic        load_wide;
  logic        ready8;
  logic [7:0]  pt8;
  logic        valid8;
  logic [7:0]  data8;
  logic        busy8;
  logic        valid1;
  logic [0:0]  data1;
  logic        busy1;
  logic        valid32;
  logic [31:0] data32;
  logic        busy32;

  int tests_run;
  int tests_failed;

  // Textbook state s1..s288 for the reference model.
  bit gs [1:288];
  bit gbits [0:1023];

  trivium_par #(.W(8)) dut8 (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .iv       (iv),
    .load     (load),
    .ks_ready (ready8),
`ifdef TRIVIUM_PAR_XOR_EN
    .pt_data  (pt8),
`endif
    .ks_valid (valid8),
    .ks_data  (data8),
    .busy     (busy8)
  );

  trivium_par #(.W(1)) dut1 (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .iv       (iv),
    .load     (load_wide),
    .ks_ready (1'b1),
`ifdef TRIVIUM_PAR_XOR_EN
    .pt_data  (1'b0),
`endif
    .ks_valid (valid1),
    .ks_data  (data1),
    .busy     (busy1)
  );

  trivium_par #(.W(32)) dut32 (
    .clk      (clk),
    .rst      (rst),
    .key      (key),
    .iv       (iv),
    .load     (load_wide),
    .ks_ready (1'b1),
`ifdef TRIVIUM_PAR_XOR_EN
    .pt_data  (32'h0),
`endif
    .ks_valid (valid32),
    .ks_data  (data32),
    .busy     (busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts every comparison and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: one keystream bit, then the state update.
  task automatic gold_step(output bit z);
    bit t1, t2, t3;
    t1 = gs[66]  ^ gs[93];
    t2 = gs[162] ^ gs[177];
    t3 = gs[243] ^ gs[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (gs[91]  & gs[92])  ^ gs[171];
    t2 = t2 ^ (gs[175] & gs[176]) ^ gs[264];
    t3 = t3 ^ (gs[286] & gs[287]) ^ gs[69];
    for (int i = 288; i >= 179; i--) gs[i] = gs[i-1];
    gs[178] = t2;
    for (int i = 177; i >= 95; i--) gs[i] = gs[i-1];
    gs[94] = t1;
    for (int i = 93; i >= 2; i--) gs[i] = gs[i-1];
    gs[1] = t3;
  endtask

  task automatic gold_load(input logic [79:0] k, input logic [79:0] v);
    bit z;
    for (int i = 1; i <= 288; i++) gs[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      gs[i]      = k[i-1];
      gs[93 + i] = v[i-1];
    end
    gs[286] = 1'b1;
    gs[287] = 1'b1;
    gs[288] = 1'b1;
    for (int i = 0; i < 1152; i++) gold_step(z);
  endtask

  task automatic gold_word(output logic [7:0] w);
    bit z;
    for (int j = 0; j < 8; j++) begin
      gold_step(z);
      w[j] = z;
    end
  endtask

  // Pulses load on the W=8 instance for one edge; returns at the negedge
  // after that edge (first warm-up cycle).
  task automatic applyStimulus(input logic [79:0] k, input logic [79:0] v);
    key  = k;
    iv   = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Measures the warm-up window of the W=8 instance.
  task automatic waitInit(input string tag);
    int cycles;
    bit leak;
    cycles = 0;
    leak   = 1'b0;
    while (busy8 && cycles < 400) begin
      if (valid8 !== 1'b0 || data8 !== 8'h00) leak = 1'b1;
      cycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_busy_cycles"}, 64'(cycles), 64'd144);
    checkOutput({tag, "_quiet"}, 64'(leak), 64'd0);
    checkOutput({tag, "_valid_rise"}, 64'(valid8), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0]  gw;
    logic [31:0] exp32;
    logic [31:0] acc;
    int          idx1;
    int          idx32;
    bit          quiet_bad;

    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    load      = 1'b0;
    load_wide = 1'b0;
    key       = '0;
    iv        = '0;
    ready8    = 1'b0;
    pt8       = 8'h00;

    // Reset state, and a load seen while reset is high is ignored.
    repeat (2) @(negedge clk);
    checkOutput("reset_valid", 64'(valid8), 64'd0);
    checkOutput("reset_busy",  64'(busy8),  64'd0);
    checkOutput("reset_data",  64'(data8),  64'd0);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b0;
    @(negedge clk);
    checkOutput("load_in_reset_busy",  64'(busy8),  64'd0);
    checkOutput("load_in_reset_valid", 64'(valid8), 64'd0);

    // Zero key/IV: 144 warm-up cycles then 64 golden words.
    ready8 = 1'b1;
    gold_load(80'h0, 80'h0);
    applyStimulus(80'h0, 80'h0);
    waitInit("zero_key");
    for (int i = 0; i < 64; i++) begin
      gold_word(gw);
      checkOutput($sformatf("zero_word%0d", i), 64'(data8), 64'(gw));
      @(negedge clk);
    end

    // Consumer stall for 5 cycles: word held, then the next word follows.
    gold_word(gw);
    checkOutput("stall_first", 64'(data8), 64'(gw));
    ready8 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("stall_hold%0d", i), 64'(data8), 64'(gw));
    end
    ready8 = 1'b1;
    @(negedge clk);
    gold_word(gw);
    checkOutput("stall_next", 64'(data8), 64'(gw));
    @(negedge clk);

    // Rekey coincident with a handshake: the word is taken, then warm-up.
    gold_word(gw);
    checkOutput("rekey_last_word",  64'(data8),  64'(gw));
    checkOutput("rekey_last_valid", 64'(valid8), 64'd1);
    gold_load(KEY2, IV2);
    applyStimulus(KEY2, IV2);
    waitInit("rekey");
    for (int i = 0; i < 8; i++) begin
      gold_word(gw);
      checkOutput($sformatf("rekey_word%0d", i), 64'(data8), 64'(gw));
      @(negedge clk);
    end

    // Reset pulsed at warm-up cycle 70 clears outputs without a clock edge.
    applyStimulus(KEY3, IV3);
    repeat (69) @(negedge clk);
    checkOutput("midinit_busy", 64'(busy8), 64'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_busy",  64'(busy8),  64'd0);
    checkOutput("async_rst_valid", 64'(valid8), 64'd0);
    checkOutput("async_rst_data",  64'(data8),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet_bad = 1'b0;
`ifdef TRIVIUM_PAR_XOR_EN
    pt8 = 8'hFF;
`endif
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid8 !== 1'b0 || busy8 !== 1'b0 || data8 !== 8'h00) quiet_bad = 1'b1;
    end
    checkOutput("post_rst_quiet", 64'(quiet_bad), 64'd0);
    pt8 = 8'h00;

    // Fresh load after reset, then the plaintext path on a held word.
    gold_load(KEY2, IV2);
    applyStimulus(KEY2, IV2);
    waitInit("reload");
    ready8 = 1'b0;
    gold_word(gw);
`ifdef TRIVIUM_PAR_XOR_EN
    pt8 = 8'hFF;
    #1;
    checkOutput("xor_ff", 64'(data8), 64'(~gw));
    pt8 = 8'h0F;
    #1;
    checkOutput("xor_0f", 64'(data8), 64'(gw ^ 8'h0F));
    pt8 = 8'h00;
    #1;
`endif
    checkOutput("reload_word0", 64'(data8), 64'(gw));
    ready8 = 1'b1;

    // W=1 and W=32 against the same 1024 golden bits, LSB-first.
    gold_load(KEY4, IV4);
    for (int i = 0; i < 1024; i++) gold_step(gbits[i]);
    @(negedge clk);
    key       = KEY4;
    iv        = IV4;
    load_wide = 1'b1;
    @(negedge clk);
    load_wide = 1'b0;
    idx1  = 0;
    idx32 = 0;
    acc   = '0;
    for (int cyc = 0; cyc < 3000 && (idx1 < 1024 || idx32 < 32); cyc++) begin
      if (valid32 && idx32 < 32) begin
        for (int b = 0; b < 32; b++) exp32[b] = gbits[idx32 * 32 + b];
        checkOutput($sformatf("w32_word%0d", idx32), 64'(data32), 64'(exp32));
        idx32++;
      end
      if (valid1 && idx1 < 1024) begin
        acc[idx1 % 32] = data1[0];
        idx1++;
        if (idx1 % 32 == 0) begin
          for (int b = 0; b < 32; b++) exp32[b] = gbits[idx1 - 32 + b];
          checkOutput($sformatf("w1_word%0d", idx1 / 32 - 1), 64'(acc), 64'(exp32));
        end
      end
      @(negedge clk);
    end
    checkOutput("w1_bits_seen",   64'(idx1),  64'd1024);
    checkOutput("w32_words_seen", 64'(idx32), 64'd32);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/trivium_par.md
TRIVIUM_PAR -- requirements
Module: trivium_par

Interface
REQ-001 The block SHALL have parameter W, default 8, setting keystream bits per cycle; legal values are 1, 2, 4, 8, 16, 32 and 64.
REQ-002 The block SHALL have parameter INIT_ROUNDS, default 1152, setting warm-up steps; it SHALL be a multiple of W.
REQ-003 The block SHALL have port `clk`: input, 1 bit, the single clock; all flops are rising-edge.
REQ-004 The block SHALL have port `rst`: input, 1 bit; reset is asynchronous and active-high.
REQ-005 The block SHALL have port `key`: input, 80 bits, key, sampled on load.
REQ-006 The block SHALL have port `iv`: input, 80 bits, IV, sampled on load.
REQ-007 The block SHALL have port `load`: input, 1 bit, a single-cycle request to (re)key.
REQ-008 The block SHALL have port `ks_ready`: input, 1 bit, the consumer accepting a keystream word.
REQ-009 The block SHALL have port `ks_valid`: output, 1 bit, high when the keystream word on `ks_data` is valid.
REQ-010 The block SHALL have port `ks_data`: output, W bits, the keystream word; bit 0 is the earliest bit in time.
REQ-011 The block SHALL have port `busy`: output, 1 bit, high during warm-up.

Function
REQ-012 State SHALL be the 288-bit Trivium state s1..s288 using the standard taps, AND terms and output z = t1^t2^t3.
REQ-013 Load mapping SHALL be: s1..s80 = key[0..79]; s94..s173 = iv[0..79]; s286..s288 = 1; all other bits = 0.
REQ-014 The FSM SHALL have states IDLE, INIT and RUN; the reset state SHALL be IDLE.
REQ-015 When `load` = 1 on an edge in any state, the block SHALL load `key` and `iv`, clear the round counter and enter INIT.
REQ-016 In INIT, each cycle SHALL advance the state by W steps with no output; `busy` = 1 and `ks_valid` = 0.
REQ-017 After INIT_ROUNDS/W INIT cycles, the block SHALL enter RUN.
REQ-018 With W=8 and the default INIT_ROUNDS, `load` at edge 0 SHALL give `ks_valid` = 1 after edge 144.
REQ-019 In RUN, `ks_valid` SHALL be 1, and `ks_data[j]` SHALL be z of the state advanced j steps, for j = 0..W-1.
REQ-020 In RUN, the state SHALL advance W steps only on an edge where `ks_valid` and `ks_ready` are both 1.
REQ-021 While `ks_ready` = 0, `ks_data` SHALL hold stable with no loss or duplication of keystream bits.
REQ-022 `ks_data` SHALL be all-zero whenever `ks_valid` = 0.
REQ-023 When `load` and a handshake coincide in RUN, `load` SHALL win: the transfer completes at the consumer, and `ks_valid` is 0 from the next cycle.
REQ-024 The W-step update SHALL be an unrolled combinational chain of single steps.
REQ-025 Output for any W SHALL equal the W=1 bitstream, concatenated LSB-first.
REQ-026 The round counter SHALL be exactly $clog2(INIT_ROUNDS/W + 1) bits wide and SHALL NOT wrap within INIT.
REQ-027 RUN SHALL continue indefinitely, with no keystream length limit.

Reset
REQ-028 While `rst` = 1, asynchronously: state register = 0, FSM = IDLE, counter = 0, `ks_valid` = 0, `busy` = 0 and `ks_data` = 0.
REQ-029 Reset asserted mid-INIT or mid-RUN SHALL abort the operation immediately.
REQ-030 After reset, a fresh `load` SHALL be required before any output.
REQ-031 `load` sampled while `rst` = 1 SHALL be ignored.

Configuration
REQ-032 Macro TRIVIUM_PAR_XOR_EN SHALL control the integrated XOR data path.
REQ-033 With TRIVIUM_PAR_XOR_EN defined, the block SHALL have input `pt_data` [W-1:0].
REQ-034 With TRIVIUM_PAR_XOR_EN defined, `ks_data` SHALL be keystream ^ `pt_data` while `ks_valid` = 1; the output is combinational from `pt_data`, and handshake and zeroing are unchanged.
REQ-035 With TRIVIUM_PAR_XOR_EN undefined, `pt_data` SHALL be absent and `ks_data` SHALL be raw keystream.

Verification
REQ-036 Bench SHALL cover: W=8, `key` = 0, `iv` = 0, `load` at cycle 0 -> `busy` = 1 for 144 cycles, `ks_valid` rises at cycle 145, and 64 words match the bit-serial golden model.
REQ-037 Bench SHALL cover: W=1 and W=32 instances with the same key/IV and `ks_ready` = 1 -> the first 1024 bits are identical in LSB-first order.
REQ-038 Bench SHALL cover: RUN with `ks_ready` = 0 for 5 cycles -> `ks_data` is constant, and the next word after release equals the golden word n+1.
REQ-039 Bench SHALL cover: `rst` pulsed at INIT cycle 70 -> `busy` = 0, `ks_valid` = 0 and `ks_data` = 0 asynchronously, and there is no output until a new `load`.
REQ-040 Bench SHALL cover: `load` with a new key during RUN, coincident with a handshake -> that word is accepted, `ks_valid` = 0 for 144 cycles, then the new-key stream follows.
REQ-041 Bench SHALL cover: TRIVIUM_PAR_XOR_EN defined with `pt_data` = 8'hFF -> `ks_data` equals the bitwise inverse of the golden keystream word.
